// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the RV32 major-opcode constants, the controller FSM state encoding
// and the operand-forwarding select encoding. It also provides the helper
// that resolves forwarding priority.
package pipe_hazard_ctrl_pkg;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } ctl_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,  // register file
    FWD_EX = 2'b01,  // result of the instruction now in EX
    FWD_WB = 2'b10   // result of the instruction now in WB
  } fwd_sel_e;

  // The younger producer (EX) holds the newer value, so it wins over WB.
  function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic wb_hit);
    if (ex_hit)      return FWD_EX;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_slot_class.sv
// Per-instruction decode used for hazard detection.
// Ports:
//   valid    - instruction present; every output is forced low when 0
//   opcode   - major opcode [6:0]
//   rd       - destination register
//   wr       - writes a non-x0 register
//   late     - result only available after EX (LOAD, CSR)
//   uses_rs1 - reads rs1
//   uses_rs2 - reads rs2
module pipe_slot_class
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  output logic       wr,
  output logic       late,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  logic writes;
  logic reads1;
  logic reads2;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    writes = 1'b0;
    reads1 = 1'b0;
    reads2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: writes = 1'b1;
      OP_JALR, OP_LOAD, OP_ARI_I, OP_CSR: begin
        writes = 1'b1;
        reads1 = 1'b1;
      end
      OP_ARI_R: begin
        writes = 1'b1;
        reads1 = 1'b1;
        reads2 = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        reads1 = 1'b1;
        reads2 = 1'b1;
      end
      default: ;
    endcase
  end

  // rd == x0 is never a producer, which keeps x0 out of forwarding and stalls.
  assign wr       = valid & writes & (rd != 5'd0);
  assign late     = valid & ((opcode == OP_LOAD) | (opcode == OP_CSR));
  assign uses_rs1 = valid & reads1;
  assign uses_rs2 = valid & reads2;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// It tracks the instructions in EX and WB, forwards their results into
// operands entering EX, stalls on load-use hazards, squashes on redirects
// and freezes on a busy data memory.
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   id_valid/opcode/rs1/rs2/rd         - decoded ID-stage instruction
//   ex_redirect                        - taken branch/jump resolved in EX
//   dmem_busy                          - data memory not ready, freeze all
//   stall_if, stall_id                 - hold PC and IF/ID
//   stall_ex                           - hold EX and WB registers
//   bubble_ex                          - insert NOP into EX
//   fwd_a, fwd_b                       - operand source select (fwd_sel_e)
//   ctl_state                          - FSM state (ctl_state_e)
//   stall_cnt, flush_cnt               - wrapping performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       ctl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // EX slot keeps the raw opcode; its class is re-derived by a decoder below.
  logic       ex_v;
  logic [6:0] ex_op;
  logic [4:0] ex_rd;
  // WB slot only needs what forwarding consumes.
  logic       wb_v;
  logic [4:0] wb_rd;
  logic       wb_wr;

  ctl_state_e state_q, state_d;

  logic id_uses_rs1, id_uses_rs2, id_wr_unused, id_late_unused;
  logic ex_wr, ex_late, ex_uses_rs1_unused, ex_uses_rs2_unused;

  pipe_slot_class u_id_class (
    .valid    (id_valid),
    .opcode   (id_opcode),
    .rd       (id_rd),
    .wr       (id_wr_unused),
    .late     (id_late_unused),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2)
  );

  pipe_slot_class u_ex_class (
    .valid    (ex_v),
    .opcode   (ex_op),
    .rd       (ex_rd),
    .wr       (ex_wr),
    .late     (ex_late),
    .uses_rs1 (ex_uses_rs1_unused),
    .uses_rs2 (ex_uses_rs2_unused)
  );

  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, load_use;

  assign ex_hit_a = ex_wr & id_uses_rs1 & (ex_rd == id_rs1);
  assign ex_hit_b = ex_wr & id_uses_rs2 & (ex_rd == id_rs2);
  assign wb_hit_a = wb_v & wb_wr & id_uses_rs1 & (wb_rd == id_rs1);
  assign wb_hit_b = wb_v & wb_wr & id_uses_rs2 & (wb_rd == id_rs2);
  assign load_use = id_valid & ex_late & (ex_hit_a | ex_hit_b);

  assign fwd_a     = fwd_pick(ex_hit_a, wb_hit_a);
  assign fwd_b     = fwd_pick(ex_hit_b, wb_hit_b);
  assign ctl_state = state_q;

  logic hold_slots, kill_ex, inc_stall, inc_flush;

  // Memory freeze outranks redirect, and redirect outranks load-use: a
  // squashed consumer must not also be stalled.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    hold_slots = 1'b0;
    kill_ex    = 1'b0;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;
    state_d    = ST_RUN;
    if (dmem_busy) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      hold_slots = 1'b1;
      inc_stall  = 1'b1;
      state_d    = ST_MEMWAIT;
    end else if (ex_redirect) begin
      bubble_ex  = 1'b1;
      kill_ex    = 1'b1;
      inc_flush  = 1'b1;
      state_d    = ST_FLUSH;
    end else if (load_use) begin
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      bubble_ex  = 1'b1;
      kill_ex    = 1'b1;
      inc_stall  = 1'b1;
      state_d    = ST_LDSTALL;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ex_v      <= 1'b0;
      wb_v      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (inc_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (inc_flush) flush_cnt <= flush_cnt + CNT_W'(1);
      if (!hold_slots) begin
        wb_v <= ex_v;
        ex_v <= id_valid & ~kill_ex;
      end
    end
  end

  // NOTE: payload fields are qualified by the valid bits above, so they need
  // no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (!hold_slots) begin
      wb_rd <= ex_rd;
      wb_wr <= ex_wr;
      ex_op <= id_opcode;
      ex_rd <= id_rd;
    end
  end

endmodule
